// File: rtl/register_bank.sv
// General-purpose register bank with one register doubling as program counter.
// Two combinational read ports with optional write-through forwarding.
module register_bank #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int PC_INDEX = NREGS - 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] BusIn,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic             PcIncr,
    input  logic [AW-1:0]    RdAddrA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] RdDataA,
    output logic [WIDTH-1:0] RdDataB,
    output logic [WIDTH-1:0] PcOut,
    output logic             PcWrap
);

    localparam logic [AW:0]       NREGS_W = (AW + 1)'(NREGS);
    localparam logic [AW-1:0]     PC_ADDR = AW'(PC_INDEX);
    localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_ok;
    logic             wr_pc;
    logic             pc_inc;

    // A write to the PC outranks a same-cycle increment.
    assign wr_ok  = WrEn && ({1'b0, WrAddr} < NREGS_W);
    assign wr_pc  = wr_ok && (WrAddr == PC_ADDR);
    assign pc_inc = PcIncr && !wr_pc;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            PcWrap <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_ok && (WrAddr == AW'(i))) begin
                    regs[i] <= BusIn;
                end else if ((i == PC_INDEX) && pc_inc) begin
                    regs[i] <= regs[i] + ONE;
                end
            end
            PcWrap <= pc_inc && (regs[PC_INDEX] == '1);
        end
    end

    // Forwarding covers bus writes only; a pending PC increment is never forwarded.
    always_comb begin
        RdDataA = '0;
        if ({1'b0, RdAddrA} < NREGS_W) begin
            RdDataA = regs[RdAddrA];
        end
        if ((BYPASS != 0) && wr_ok && (WrAddr == RdAddrA)) begin
            RdDataA = BusIn;
        end
    end

    always_comb begin
        RdDataB = '0;
        if ({1'b0, RdAddrB} < NREGS_W) begin
            RdDataB = regs[RdAddrB];
        end
        if ((BYPASS != 0) && wr_ok && (WrAddr == RdAddrB)) begin
            RdDataB = BusIn;
        end
    end

    assign PcOut = regs[PC_INDEX];

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the bit width of every register and data port.
REQ-002 The block SHALL have parameter NREGS, default 8, the register count (2..256).
REQ-003 The block SHALL have parameter PC_INDEX, default NREGS-1, the index of the register that also acts as program counter.
REQ-004 The block SHALL have parameter BYPASS, default 1; 1 = write-through to read ports, 0 = no forwarding.
REQ-005 The block SHALL have parameter AW, default clog2(NREGS), the address width.
REQ-006 The block SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port BusIn, input, WIDTH, write data from the processor bus.
REQ-009 The block SHALL have port WrEn, input, 1, write enable.
REQ-010 The block SHALL have port WrAddr, input, AW, write register index.
REQ-011 The block SHALL have port PcIncr, input, 1, PC increment request.
REQ-012 The block SHALL have ports RdAddrA and RdAddrB, input, AW each, read indexes.
REQ-013 The block SHALL have ports RdDataA and RdDataB, output, WIDTH each, read data.
REQ-014 The block SHALL have port PcOut, output, WIDTH, current value of register PC_INDEX.
REQ-015 The block SHALL have port PcWrap, output, 1, registered one-cycle pulse flagging a PC increment that wrapped.

Function
REQ-016 Storage SHALL be NREGS registers of WIDTH bits, R0..R(NREGS-1).
REQ-017 On a rising Clock with WrEn=1 and WrAddr<NREGS, R[WrAddr] SHALL load BusIn; every other register SHALL hold, except the PC per REQ-018.
REQ-018 On a rising Clock with PcIncr=1 and no write to PC_INDEX, R[PC_INDEX] SHALL load R[PC_INDEX]+1 modulo 2^WIDTH.
REQ-019 Simultaneous WrEn=1 to PC_INDEX and PcIncr=1: the write SHALL win, no increment SHALL occur, and PcWrap SHALL stay 0.
REQ-020 Simultaneous WrEn=1 to another index and PcIncr=1: both updates SHALL occur in the same cycle.
REQ-021 PC wrap: an increment from all-ones SHALL yield 0, and PcWrap SHALL be 1 for exactly the following cycle.
REQ-022 PcWrap SHALL otherwise be 0.
REQ-023 Reads SHALL be combinational, with zero-cycle latency: RdDataX = R[RdAddrX].
REQ-024 If BYPASS=1, WrEn=1, WrAddr==RdAddrX and WrAddr<NREGS, then RdDataX SHALL equal BusIn in that cycle.
REQ-025 Bypass SHALL NOT apply to pending PC increments; reads of PC_INDEX return the pre-edge value.
REQ-026 If BYPASS=0, reads SHALL return the stored value only, with the write visible from the cycle after the edge.
REQ-027 Out-of-range WrAddr (>=NREGS) SHALL be ignored with no state change; out-of-range RdAddrX SHALL return 0.
REQ-028 PcOut SHALL always equal stored R[PC_INDEX], with no bypass.
REQ-029 Both read ports SHALL be independent and SHALL permit the same address simultaneously.

Reset
REQ-030 Reset=1 SHALL immediately, without waiting for a clock edge, force all registers to 0, PcOut to 0, PcWrap to 0, and RdDataX to 0 unless bypassing.
REQ-031 While Reset=1, writes and increments SHALL be ignored.
REQ-032 Reset deassertion SHALL take effect at the next rising Clock.
REQ-033 Reset asserted mid-operation, including in the same cycle as a write, SHALL discard the write.

Verification
REQ-034 Reset, then WrEn=1, WrAddr=3, BusIn=16'hBEEF, then RdAddrA=3 -> RdDataA=16'hBEEF after the edge; all others read 0.
REQ-035 BYPASS=1 with WrEn=1, WrAddr=2, BusIn=16'h1234, RdAddrB=2 in the same cycle -> RdDataB=16'h1234 before the edge; with BYPASS=0 -> old value 0.
REQ-036 PC preset to 16'hFFFE, PcIncr=1 for 3 cycles -> PcOut goes FFFF, 0000, 0001; PcWrap=1 only in the cycle PcOut=0000.
REQ-037 WrEn=1, WrAddr=7, BusIn=16'h0040 together with PcIncr=1 -> PcOut=16'h0040, not 0041; PcWrap=0.
REQ-038 Registers loaded with nonzero values, then Reset pulsed between clock edges -> all outputs 0 immediately; a write in that window is lost.
REQ-039 NREGS=6, AW=3: write to WrAddr=7 -> no register changes; RdAddrA=6 -> RdDataA=0.
